// File: rtl/axis_pattern_generator.sv
// axis_pattern_generator
// AXI4-Stream test-pattern source (increment / constant / Galois LFSR) with
// packetisation, multi-packet and continuous runs, abort and beat counting.
// Configured and monitored through a small AXI4-Lite register slave.
module axis_pattern_generator #(
    parameter int DATA_WIDTH = 32,
    parameter int TID_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // AXI4-Stream master
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic [TID_WIDTH-1:0]    m_axis_tid,
    // AXI4-Lite slave
    input  logic [7:0]              s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [7:0]              s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_STATUS   = 6'h01;
    localparam logic [5:0] ADDR_INIT     = 6'h02;
    localparam logic [5:0] ADDR_STEP     = 6'h03;
    localparam logic [5:0] ADDR_PKT_LEN  = 6'h04;
    localparam logic [5:0] ADDR_NUM_PKTS = 6'h05;
    localparam logic [5:0] ADDR_BEAT_CNT = 6'h06;

    localparam logic [1:0]  MODE_CONST = 2'd1;
    localparam logic [1:0]  MODE_LFSR  = 2'd2;
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

    // LOAD is the one-cycle gap between shadowing the config and presenting
    // the first beat, so the first beat appears two cycles after the START write.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Programmable configuration (what the CPU sees)
    logic        cfg_cont_reg;
    logic [1:0]  cfg_mode_reg;
    logic [7:0]  cfg_tid_reg;
    logic [31:0] cfg_init_reg;
    logic [31:0] cfg_step_reg;
    logic [31:0] cfg_len_reg;
    logic [31:0] cfg_num_reg;

    // Shadow copy used by the running generator
    logic                 sh_cont_reg;
    logic [1:0]           sh_mode_reg;
    logic [TID_WIDTH-1:0] sh_tid_reg;
    logic [31:0]          sh_step_reg;
    logic [31:0]          sh_len_reg;
    logic [31:0]          sh_num_reg;

    // Generator datapath
    logic [31:0] pat_reg;
    logic [31:0] beat_idx_reg;
    logic [31:0] pkt_idx_reg;
    logic [31:0] beat_cnt_reg;
    logic        tvalid_reg;
    logic        tlast_reg;
    logic        done_reg;
    logic        aborted_reg;

    // Command pulses from CTRL writes
    logic start_req_reg;
    logic stop_req_reg;

    // FSM decisions consumed by the datapath
    logic load_cfg;
    logic zero_run;
    logic finish_run;
    logic abort_run;
    logic force_last;
    logic advance;

    logic        fire;
    logic        last_beat;
    logic        final_beat;
    logic        cfg_zero;
    logic        wr_fire;
    logic        rd_fire;
    logic [5:0]  wr_addr;
    logic [5:0]  rd_addr;
    logic [31:0] rd_mux;
    logic [31:0] pat_next;
    logic [31:0] seed;

    // Address byte-offset bits and byte strobes carry no information here
    logic unused_ok;
    assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb};

    assign wr_fire = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
    assign rd_fire = s_axi_arready & s_axi_arvalid;
    assign wr_addr = s_axi_awaddr[7:2];
    assign rd_addr = s_axi_araddr[7:2];

    assign s_axi_bresp  = 2'b00;
    assign s_axi_rresp  = 2'b00;

    assign m_axis_tdata  = pat_reg[DATA_WIDTH-1:0];
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tlast  = tlast_reg;
    assign m_axis_tid    = sh_tid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_strb
            assign m_axis_tstrb[gi] = 1'b1;
            assign m_axis_tkeep[gi] = 1'b1;
        end
    endgenerate

    assign fire       = tvalid_reg & m_axis_tready;
    assign last_beat  = (beat_idx_reg == sh_len_reg - 32'd1);
    assign final_beat = last_beat && !sh_cont_reg && (pkt_idx_reg == sh_num_reg - 32'd1);
    assign cfg_zero   = (cfg_len_reg == 32'd0) || ((cfg_num_reg == 32'd0) && !cfg_cont_reg);
    assign seed       = ((cfg_mode_reg == MODE_LFSR) && (cfg_init_reg == 32'd0)) ? 32'd1 : cfg_init_reg;

    // Next pattern value after a handshake; reserved mode 3 falls back to increment
    always_comb begin
        pat_next = pat_reg + sh_step_reg;
        case (sh_mode_reg)
            MODE_CONST: pat_next = pat_reg;
            MODE_LFSR:  pat_next = (pat_reg >> 1) ^ (pat_reg[0] ? LFSR_TAPS : 32'd0);
            default:    pat_next = pat_reg + sh_step_reg;
        endcase
    end

    // Register read multiplexer; unmapped offsets read as zero
    always_comb begin
        rd_mux = 32'd0;
        case (rd_addr)
            ADDR_CTRL:     rd_mux = {16'd0, cfg_tid_reg, 2'b00, cfg_mode_reg, 1'b0, cfg_cont_reg, 2'b00};
            ADDR_STATUS:   rd_mux = {29'd0, aborted_reg, done_reg, (state_reg != ST_IDLE)};
            ADDR_INIT:     rd_mux = cfg_init_reg;
            ADDR_STEP:     rd_mux = cfg_step_reg;
            ADDR_PKT_LEN:  rd_mux = cfg_len_reg;
            ADDR_NUM_PKTS: rd_mux = cfg_num_reg;
            ADDR_BEAT_CNT: rd_mux = beat_cnt_reg;
            default:       rd_mux = 32'd0;
        endcase
    end

    // AXI-Lite handshakes: single-cycle ready pulses, responses held until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= 32'd0;
        end else begin
            s_axi_awready <= !s_axi_awready && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
            s_axi_wready  <= !s_axi_awready && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
            if (wr_fire) begin
                s_axi_bvalid <= 1'b1;
            end else if (s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            s_axi_arready <= !s_axi_arready && s_axi_arvalid && !s_axi_rvalid;
            if (rd_fire) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_mux;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    // Configuration registers and the registered START/STOP pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_cont_reg  <= 1'b0;
            cfg_mode_reg  <= 2'd0;
            cfg_tid_reg   <= 8'd0;
            cfg_init_reg  <= 32'd0;
            cfg_step_reg  <= 32'd0;
            cfg_len_reg   <= 32'd0;
            cfg_num_reg   <= 32'd0;
            start_req_reg <= 1'b0;
            stop_req_reg  <= 1'b0;
        end else begin
            start_req_reg <= wr_fire && (wr_addr == ADDR_CTRL) && s_axi_wdata[0];
            stop_req_reg  <= wr_fire && (wr_addr == ADDR_CTRL) && s_axi_wdata[1];
            if (wr_fire) begin
                case (wr_addr)
                    ADDR_CTRL: begin
                        cfg_cont_reg <= s_axi_wdata[2];
                        cfg_mode_reg <= s_axi_wdata[5:4];
                        cfg_tid_reg  <= s_axi_wdata[15:8];
                    end
                    ADDR_INIT:     cfg_init_reg <= s_axi_wdata;
                    ADDR_STEP:     cfg_step_reg <= s_axi_wdata;
                    ADDR_PKT_LEN:  cfg_len_reg  <= s_axi_wdata;
                    ADDR_NUM_PKTS: cfg_num_reg  <= s_axi_wdata;
                    default: ;
                endcase
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and the datapath actions for this cycle
    always_comb begin
        state_next = state_reg;
        load_cfg   = 1'b0;
        zero_run   = 1'b0;
        finish_run = 1'b0;
        abort_run  = 1'b0;
        force_last = 1'b0;
        advance    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_req_reg) begin
                    load_cfg = 1'b1;
                    if (cfg_zero) begin
                        zero_run = 1'b1;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (fire && final_beat) begin
                    finish_run = 1'b1;
                    state_next = ST_IDLE;
                end else if (stop_req_reg) begin
                    // A beat accepted in the STOP cycle leaves nothing to drain
                    if (fire) begin
                        abort_run  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        force_last = 1'b1;
                        state_next = ST_DRAIN;
                    end
                end else if (fire) begin
                    advance = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (fire) begin
                    abort_run  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Generator datapath: shadowing, pattern/counter update, stream flags, status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_cont_reg  <= 1'b0;
            sh_mode_reg  <= 2'd0;
            sh_tid_reg   <= '0;
            sh_step_reg  <= 32'd0;
            sh_len_reg   <= 32'd0;
            sh_num_reg   <= 32'd0;
            pat_reg      <= 32'd0;
            beat_idx_reg <= 32'd0;
            pkt_idx_reg  <= 32'd0;
            beat_cnt_reg <= 32'd0;
            tvalid_reg   <= 1'b0;
            tlast_reg    <= 1'b0;
            done_reg     <= 1'b0;
            aborted_reg  <= 1'b0;
        end else begin
            if (fire) begin
                beat_cnt_reg <= beat_cnt_reg + 32'd1;
            end
            if (load_cfg) begin
                sh_cont_reg  <= cfg_cont_reg;
                sh_mode_reg  <= cfg_mode_reg;
                sh_tid_reg   <= cfg_tid_reg[TID_WIDTH-1:0];
                sh_step_reg  <= cfg_step_reg;
                sh_len_reg   <= cfg_len_reg;
                sh_num_reg   <= cfg_num_reg;
                pat_reg      <= seed;
                beat_idx_reg <= 32'd0;
                pkt_idx_reg  <= 32'd0;
                beat_cnt_reg <= 32'd0;
                tvalid_reg   <= 1'b0;
                tlast_reg    <= 1'b0;
                done_reg     <= zero_run;
                aborted_reg  <= 1'b0;
            end
            if (state_reg == ST_LOAD) begin
                tvalid_reg <= 1'b1;
                tlast_reg  <= (sh_len_reg == 32'd1);
            end
            if (finish_run) begin
                tvalid_reg <= 1'b0;
                tlast_reg  <= 1'b0;
                done_reg   <= 1'b1;
            end
            if (abort_run) begin
                tvalid_reg  <= 1'b0;
                tlast_reg   <= 1'b0;
                aborted_reg <= 1'b1;
            end
            if (force_last) begin
                tlast_reg <= 1'b1;
            end
            if (advance) begin
                pat_reg <= pat_next;
                if (last_beat) begin
                    beat_idx_reg <= 32'd0;
                    pkt_idx_reg  <= pkt_idx_reg + 32'd1;
                    tlast_reg    <= (sh_len_reg == 32'd1);
                end else begin
                    beat_idx_reg <= beat_idx_reg + 32'd1;
                    tlast_reg    <= (beat_idx_reg + 32'd1 == sh_len_reg - 32'd1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_pattern_generator.sv
// Directed bench for axis_pattern_generator: a 32-bit and an 8-bit instance
// share one register bus and one tready so both run identical sequences.
module tb_axis_pattern_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic [3:0]  tstrb;
    logic [3:0]  tkeep;
    logic        tlast;
    logic [7:0]  tid;

    logic [7:0]  tdata8;
    logic        tvalid8;
    logic [0:0]  tstrb8;
    logic [0:0]  tkeep8;
    logic        tlast8;
    logic [3:0]  tid8;

    logic [7:0]  awaddr = 8'd0;
    logic        awvalid = 1'b0;
    logic        awready, awready8;
    logic [31:0] wdata = 32'd0;
    logic        wvalid = 1'b0;
    logic        wready, wready8;
    logic [1:0]  bresp, bresp8;
    logic        bvalid, bvalid8;
    logic [7:0]  araddr = 8'd0;
    logic        arvalid = 1'b0;
    logic        arready, arready8;
    logic [31:0] rdata, rdata8;
    logic [1:0]  rresp, rresp8;
    logic        rvalid, rvalid8;

    int checks = 0;
    int errors = 0;

    logic [31:0] cap_data [0:15];
    logic        cap_last [0:15];
    logic [7:0]  cap8     [0:15];
    int          ncap;

    always #5 clk = ~clk;

    axis_pattern_generator #(.DATA_WIDTH(32), .TID_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tstrb(tstrb), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast), .m_axis_tid(tid),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(4'hF), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(1'b1),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(1'b1)
    );

    axis_pattern_generator #(.DATA_WIDTH(8), .TID_WIDTH(4)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .m_axis_tdata(tdata8), .m_axis_tvalid(tvalid8), .m_axis_tready(tready),
        .m_axis_tstrb(tstrb8), .m_axis_tkeep(tkeep8), .m_axis_tlast(tlast8), .m_axis_tid(tid8),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready8),
        .s_axi_wdata(wdata), .s_axi_wstrb(4'hF), .s_axi_wvalid(wvalid), .s_axi_wready(wready8),
        .s_axi_bresp(bresp8), .s_axi_bvalid(bvalid8), .s_axi_bready(1'b1),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready8),
        .s_axi_rdata(rdata8), .s_axi_rresp(rresp8), .s_axi_rvalid(rvalid8), .s_axi_rready(1'b1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Returns at T+1ns, T being the write handshake edge
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data);
        int n = 0;
        awaddr  = addr;
        wdata   = data;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        while (!awready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!awready) begin
            check("aw_timeout", 32'(awready), 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        $display("WR addr %h data %h bvalid %0b", addr, data, bvalid);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data);
        int n = 0;
        araddr  = addr;
        arvalid = 1'b1;
        while (!arready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!arready) begin
            check("ar_timeout", 32'(arready), 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        data    = rvalid ? rdata : 32'hDEAD_BEEF;
        $display("RD addr %h data %h", addr, data);
        @(posedge clk); #1;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic wait_tvalid();
        int n = 0;
        while (!tvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_tvalid", 32'(tvalid), 32'd1);
    endtask

    // Drives tready (constant 1 or alternating 1/0) and captures accepted beats
    task automatic stream(input int n, input bit toggle);
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] pd = 32'd0;
        logic        pl = 1'b0;
        ncap = 0;
        while (ncap < n && cyc < 200) begin
            if (stalled) begin
                check("stall_valid", 32'(tvalid), 32'd1);
                check("stall_data", tdata, pd);
                check("stall_last", 32'(tlast), 32'(pl));
            end
            tready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (tvalid && tready) begin
                cap_data[ncap] = tdata;
                cap_last[ncap] = tlast;
                cap8[ncap]     = tdata8;
                $display("BEAT %0d data %h last %0b data8 %h", ncap, tdata, tlast, tdata8);
                ncap++;
            end
            stalled = tvalid && !tready;
            pd = tdata;
            pl = tlast;
            @(posedge clk); #1;
            cyc++;
        end
        if (ncap < n) check("stream_timeout", 32'(ncap), 32'(n));
        check("tvalid_end", 32'(tvalid), 32'd0);
        tready = 1'b1;
    endtask

    initial begin
        int hi_seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_tstrb", 32'(tstrb), 32'hF);
        check("rst_tkeep", 32'(tkeep), 32'hF);
        check("rst_tkeep8", 32'(tkeep8), 32'h1);
        check("rst_tid", 32'(tid), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd_check("rst_status", 8'h04, 32'd0);
        rd_check("rst_init", 8'h08, 32'd0);

        // Test 1: INC, INIT 5, STEP 1, 2 packets of 4
        axi_write(8'h08, 32'd5);
        axi_write(8'h0C, 32'd1);
        axi_write(8'h10, 32'd4);
        axi_write(8'h14, 32'd2);
        axi_write(8'h00, 32'h0000_0001);
        check("t1_valid_T", 32'(tvalid), 32'd0);
        @(posedge clk); #1;
        check("t1_valid_T1", 32'(tvalid), 32'd0);
        @(posedge clk); #1;
        check("t1_valid_T2", 32'(tvalid), 32'd1);
        check("t1_first", tdata, 32'd5);
        stream(8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("t1_data", cap_data[i], 32'd5 + 32'(i));
            check("t1_last", 32'(cap_last[i]), 32'((i == 3) || (i == 7)));
        end
        rd_check("t1_status", 8'h04, 32'h2);
        rd_check("t1_beats", 8'h18, 32'd8);
        rd_check("t1_ctrl", 8'h00, 32'd0);

        // Test 2: same run under alternating back-pressure
        axi_write(8'h00, 32'h0000_0001);
        stream(8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("t2_data", cap_data[i], 32'd5 + 32'(i));
            check("t2_last", 32'(cap_last[i]), 32'((i == 3) || (i == 7)));
        end
        rd_check("t2_beats", 8'h18, 32'd8);

        // Test 3: 32-bit wrap of INC with STEP = -1, also seen on the 8-bit instance
        axi_write(8'h08, 32'd0);
        axi_write(8'h0C, 32'hFFFF_FFFF);
        axi_write(8'h10, 32'd3);
        axi_write(8'h14, 32'd1);
        axi_write(8'h00, 32'h0000_0001);
        stream(3, 1'b0);
        check("t3_d0", cap_data[0], 32'h0000_0000);
        check("t3_d1", cap_data[1], 32'hFFFF_FFFF);
        check("t3_d2", cap_data[2], 32'hFFFF_FFFE);
        check("t3_b0", 32'(cap8[0]), 32'h00);
        check("t3_b1", 32'(cap8[1]), 32'hFF);
        check("t3_b2", 32'(cap8[2]), 32'hFE);
        check("t3_last", 32'(cap_last[2]), 32'd1);

        // Test 4: Galois LFSR from 1.
        // 1 -> 0 ^ 80200003 = 80200003 -> 40100001 ^ 80200003 = C0300002
        axi_write(8'h08, 32'd1);
        axi_write(8'h00, 32'h0000_0021);
        stream(3, 1'b0);
        check("t4_d0", cap_data[0], 32'h0000_0001);
        check("t4_d1", cap_data[1], 32'h8020_0003);
        check("t4_d2", cap_data[2], 32'hC030_0002);
        check("t4_last", 32'(cap_last[2]), 32'd1);

        // Test 5: continuous run stalled, ignored re-START, then STOP and drain
        tready = 1'b0;
        axi_write(8'h08, 32'h0000_0100);
        axi_write(8'h0C, 32'd1);
        axi_write(8'h10, 32'd2);
        axi_write(8'h00, 32'h0000_A505);
        wait_tvalid();
        check("t5_tid", 32'(tid), 32'hA5);
        check("t5_tid8", 32'(tid8), 32'h5);
        rd_check("t5_busy", 8'h04, 32'h1);
        rd_check("t5_ctrl", 8'h00, 32'h0000_A504);
        axi_write(8'h08, 32'h0000_0077);
        axi_write(8'h00, 32'h0000_A505);
        repeat (3) @(posedge clk);
        #1;
        check("t5_ign_valid", 32'(tvalid), 32'd1);
        check("t5_ign_data", tdata, 32'h0000_0100);
        check("t5_ign_last", 32'(tlast), 32'd0);
        axi_write(8'h00, 32'h0000_0002);
        repeat (2) @(posedge clk);
        #1;
        check("t5_stop_valid", 32'(tvalid), 32'd1);
        check("t5_stop_last", 32'(tlast), 32'd1);
        check("t5_stop_data", tdata, 32'h0000_0100);
        tready = 1'b1;
        @(posedge clk); #1;
        check("t5_drained", 32'(tvalid), 32'd0);
        rd_check("t5_status", 8'h04, 32'h4);
        rd_check("t5_beats", 8'h18, 32'd1);

        // Test 6a: PKT_LEN 0 sends nothing and completes at once
        axi_write(8'h10, 32'd0);
        axi_write(8'h00, 32'h0000_0001);
        hi_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (tvalid) hi_seen++;
            @(posedge clk); #1;
        end
        check("t6_no_valid", 32'(hi_seen), 32'd0);
        rd_check("t6_status", 8'h04, 32'h2);
        rd_check("t6_beats", 8'h18, 32'd0);

        // Test 6b: asynchronous reset while a beat is pending
        tready = 1'b0;
        axi_write(8'h10, 32'd4);
        axi_write(8'h08, 32'h0000_0055);
        axi_write(8'h00, 32'h0000_1201);
        wait_tvalid();
        check("t6_pending", tdata, 32'h0000_0055);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(tvalid), 32'd0);
        check("t6_rst_data", tdata, 32'd0);
        check("t6_rst_data8", 32'(tdata8), 32'd0);
        check("t6_rst_tid", 32'(tid), 32'd0);
        check("t6_rst_tkeep", 32'(tkeep), 32'hF);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tready = 1'b1;
        @(posedge clk); #1;
        rd_check("t6_rst_status", 8'h04, 32'd0);
        rd_check("t6_rst_init", 8'h08, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
